// File: rtl/neosd_init_seq.sv
// SD-card identification sequencer: power-up clocks, CMD0, CMD8, CMD55/ACMD41 poll,
// CMD2 and CMD3, driving the command FSM in place of software.
module neosd_init_seq #(
    parameter int          INIT_CLKS      = 80,
    parameter int          ACMD41_RETRIES = 1000,
    parameter logic [31:0] OCR_WINDOW     = 32'h00FF8000
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic        clkstrb_i,
    output logic        sd_clk_req_o,
    output logic        cmd_start_o,
    output logic [5:0]  cmd_idx_o,
    output logic [31:0] cmd_arg_o,
    output logic [1:0]  cmd_rmode_o,
    input  logic        cmd_done_i,
    input  logic        cmd_err_i,
    input  logic [31:0] cmd_resp_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [2:0]  err_code_o,
    output logic        v1_card_o,
    output logic        ccs_o,
    output logic [15:0] rca_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_PWRUP, S_CMD0, S_CMD8, S_CMD55, S_ACMD41, S_CMD2, S_CMD3, S_DONE, S_ERR
    } state_t;

    localparam logic [15:0] STRB_LAST = 16'(INIT_CLKS - 1);
    localparam logic [15:0] RETRY_MAX = 16'(ACMD41_RETRIES);

    state_t      state_q, state_d;
    logic        issue_q, issue_d;
    logic [15:0] strb_cnt_q, strb_cnt_d;
    logic [15:0] retry_q, retry_d;
    logic [15:0] retry_inc;
    logic        sd_clk_req_q, sd_clk_req_d;
    logic        cmd_start_q, cmd_start_d;
    logic [5:0]  cmd_idx_q, cmd_idx_d;
    logic [31:0] cmd_arg_q, cmd_arg_d;
    logic [1:0]  cmd_rmode_q, cmd_rmode_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [2:0]  err_code_q, err_code_d;
    logic        v1_card_q, v1_card_d;
    logic        ccs_q, ccs_d;
    logic [15:0] rca_q, rca_d;

    always_comb begin
        state_d     = state_q;
        issue_d     = issue_q;
        strb_cnt_d  = strb_cnt_q;
        retry_d     = retry_q;
        cmd_start_d = 1'b0;
        cmd_idx_d   = cmd_idx_q;
        cmd_arg_d   = cmd_arg_q;
        cmd_rmode_d = cmd_rmode_q;
        done_d      = done_q;
        err_d       = err_q;
        err_code_d  = err_code_q;
        v1_card_d   = v1_card_q;
        ccs_d       = ccs_q;
        rca_d       = rca_q;
        retry_inc   = (retry_q == 16'hFFFF) ? retry_q : retry_q + 16'd1;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                // A simultaneous abort suppresses the start.
                if (start_i && !abort_i) begin
                    state_d    = S_PWRUP;
                    issue_d    = 1'b0;
                    strb_cnt_d = '0;
                    retry_d    = '0;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    err_code_d = 3'd0;
                    v1_card_d  = 1'b0;
                    ccs_d      = 1'b0;
                    rca_d      = '0;
                end
            end
            default: begin
                if (abort_i) begin
                    state_d    = S_ERR;
                    issue_d    = 1'b0;
                    err_d      = 1'b1;
                    err_code_d = 3'd4;
                end else if (state_q == S_PWRUP) begin
                    if (clkstrb_i) begin
                        if (strb_cnt_q == STRB_LAST) begin
                            state_d = S_CMD0;
                            issue_d = 1'b1;
                        end else begin
                            strb_cnt_d = strb_cnt_q + 16'd1;
                        end
                    end
                end else if (issue_q) begin
                    issue_d = 1'b0;
                end else if (cmd_done_i) begin
                    issue_d = 1'b1;
                    case (state_q)
                        S_CMD0: state_d = S_CMD8;
                        S_CMD8: begin
                            if (cmd_err_i) begin
                                v1_card_d = 1'b1;
                                state_d   = S_CMD55;
                            end else if (cmd_resp_i[11:0] == 12'h1AA) begin
                                state_d = S_CMD55;
                            end else begin
                                state_d    = S_ERR;
                                err_code_d = 3'd1;
                            end
                        end
                        S_CMD55: state_d = cmd_err_i ? S_ERR : S_ACMD41;
                        S_ACMD41: begin
                            if (cmd_err_i) begin
                                state_d = S_ERR;
                            end else begin
                                retry_d = retry_inc;
                                if (cmd_resp_i[31]) begin
                                    ccs_d   = cmd_resp_i[30] & ~v1_card_q;
                                    state_d = S_CMD2;
                                end else if (retry_inc == RETRY_MAX) begin
                                    state_d    = S_ERR;
                                    err_code_d = 3'd2;
                                end else begin
                                    state_d = S_CMD55;
                                end
                            end
                        end
                        S_CMD2: state_d = cmd_err_i ? S_ERR : S_CMD3;
                        S_CMD3: begin
                            if (cmd_err_i) begin
                                state_d = S_ERR;
                            end else begin
                                rca_d   = cmd_resp_i[31:16];
                                done_d  = 1'b1;
                                state_d = S_DONE;
                            end
                        end
                        default: state_d = S_ERR;
                    endcase
                    if (state_d == S_ERR) begin
                        issue_d = 1'b0;
                        err_d   = 1'b1;
                        if (err_code_d == 3'd0) err_code_d = 3'd3;
                    end else if (state_d == S_DONE) begin
                        issue_d = 1'b0;
                    end
                end
            end
        endcase

        // Command fields are latched on entry to ISSUE and held through WAIT.
        if (issue_d && !issue_q) begin
            cmd_start_d = 1'b1;
            cmd_arg_d   = 32'h0;
            cmd_rmode_d = 2'd1;
            case (state_d)
                S_CMD0:   begin cmd_idx_d = 6'd0;  cmd_rmode_d = 2'd0; end
                S_CMD8:   begin cmd_idx_d = 6'd8;  cmd_arg_d = 32'h000001AA; end
                S_CMD55:  cmd_idx_d = 6'd55;
                S_ACMD41: begin
                    cmd_idx_d   = 6'd41;
                    cmd_rmode_d = 2'd3;
                    cmd_arg_d   = OCR_WINDOW | (v1_card_d ? 32'h0 : 32'h40000000);
                end
                S_CMD2:   begin cmd_idx_d = 6'd2;  cmd_rmode_d = 2'd2; end
                default:  cmd_idx_d = 6'd3;
            endcase
        end

        sd_clk_req_d = (state_d == S_PWRUP);
        busy_d       = !(state_d inside {S_IDLE, S_DONE, S_ERR});
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= S_IDLE;
            issue_q      <= 1'b0;
            strb_cnt_q   <= '0;
            retry_q      <= '0;
            sd_clk_req_q <= 1'b0;
            cmd_start_q  <= 1'b0;
            cmd_idx_q    <= '0;
            cmd_arg_q    <= '0;
            cmd_rmode_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= '0;
            v1_card_q    <= 1'b0;
            ccs_q        <= 1'b0;
            rca_q        <= '0;
        end else begin
            state_q      <= state_d;
            issue_q      <= issue_d;
            strb_cnt_q   <= strb_cnt_d;
            retry_q      <= retry_d;
            sd_clk_req_q <= sd_clk_req_d;
            cmd_start_q  <= cmd_start_d;
            cmd_idx_q    <= cmd_idx_d;
            cmd_arg_q    <= cmd_arg_d;
            cmd_rmode_q  <= cmd_rmode_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            v1_card_q    <= v1_card_d;
            ccs_q        <= ccs_d;
            rca_q        <= rca_d;
        end
    end

    assign sd_clk_req_o = sd_clk_req_q;
    assign cmd_start_o  = cmd_start_q;
    assign cmd_idx_o    = cmd_idx_q;
    assign cmd_arg_o    = cmd_arg_q;
    assign cmd_rmode_o  = cmd_rmode_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign err_code_o   = err_code_q;
    assign v1_card_o    = v1_card_q;
    assign ccs_o        = ccs_q;
    assign rca_o        = rca_q;

endmodule

// File: doc/neosd_init_seq.md
Name: neosd_init_seq

Overview:
Hardware SD-card initialization sequencer. It drives the command FSM's start/index/argument/response-mode inputs in place of software. On start_i it runs the standard identification flow: power-up clocks, CMD0, CMD8, the CMD55+ACMD41 poll loop, CMD2 and CMD3. It reports card type, RCA and completion or error status to the register block.

Parameters:
INIT_CLKS, 80, number of SD clock strobes (clkstrb_i pulses) generated before CMD0; minimum legal value 74.
ACMD41_RETRIES, 1000, maximum ACMD41 attempts before giving up; range 1..65535.
OCR_WINDOW, 32'h00FF8000, voltage window OR'd into the ACMD41 argument.

Ports:
clk_i  in  1  system clock
rstn_i  in  1  reset
start_i  in  1  single-cycle pulse: begin initialization
abort_i  in  1  level: abandon sequence (driven from CTRL.ABRT)
clkstrb_i  in  1  one-cycle strobe per SD clock period
sd_clk_req_o  out  1  request SD clock during power-up phase
cmd_start_o  out  1  single-cycle command-issue pulse to the command FSM
cmd_idx_o  out  6  command index
cmd_arg_o  out  32  command argument
cmd_rmode_o  out  2  response mode: 0 none, 1 R1 48-bit, 2 R2 136-bit, 3 R3 48-bit with CRC ignored
cmd_done_i  in  1  single-cycle pulse: command (and response, if any) finished
cmd_err_i  in  1  qualifies cmd_done_i: timeout or CRC error
cmd_resp_i  in  32  response bits [39:8], valid with cmd_done_i
busy_o  out  1  sequence in progress
done_o  out  1  sequence completed successfully (sticky)
err_o  out  1  sequence failed (sticky)
err_code_o  out  3  1 CMD8 echo mismatch, 2 ACMD41 retries exhausted, 3 command error, 4 aborted
v1_card_o  out  1  card did not answer CMD8
ccs_o  out  1  high-capacity card (OCR bit 30)
rca_o  out  16  relative card address from CMD3

Behaviour:
- Reset is asynchronous, active-low, on rstn_i; clock is clk_i.
- Reset values: every output is 0; state is IDLE; retry counter and strobe counter are 0.
- States: IDLE, PWRUP, CMD0, CMD8, CMD55, ACMD41, CMD2, CMD3, DONE, ERR.
- Each CMDx state has two phases, ISSUE then WAIT.
  - ISSUE lasts exactly 1 cycle and asserts cmd_start_o.
  - cmd_idx_o, cmd_arg_o and cmd_rmode_o are valid in the ISSUE cycle and held stable until WAIT exits.
  - WAIT lasts until cmd_done_i.
- start_i:
  - In IDLE, DONE or ERR: clears done_o, err_o, err_code_o, v1_card_o, ccs_o, rca_o and the retry counter, then enters PWRUP next cycle.
  - In any other state: ignored.
- busy_o = 1 in every state except IDLE, DONE and ERR.
- PWRUP: sd_clk_req_o = 1; counts clkstrb_i pulses; after the INIT_CLKS-th pulse, enters CMD0 next cycle. sd_clk_req_o = 0 in all other states.
- CMD0: idx 0, arg 0, rmode 0. On cmd_done_i go to CMD8; cmd_err_i is ignored here.
- CMD8: idx 8, arg 32'h000001AA, rmode 1.
  - done with err: v1_card_o <= 1, go to CMD55.
  - done, no err, resp[11:0] == 12'h1AA: go to CMD55.
  - done, no err, any other resp[11:0]: ERR, code 1.
- CMD55: idx 55, arg 0, rmode 1. done without err goes to ACMD41.
- ACMD41: idx 41, arg = OCR_WINDOW | (v1_card_o ? 0 : 32'h40000000), rmode 3.
  - On each cmd_done_i without err, the retry counter increments.
  - resp[31] == 1: ccs_o <= resp[30] & ~v1_card_o, go to CMD2.
  - resp[31] == 0 and counter == ACMD41_RETRIES: ERR, code 2.
  - resp[31] == 0 otherwise: back to CMD55.
- CMD2: idx 2, arg 0, rmode 2. done goes to CMD3.
- CMD3: idx 3, arg 0, rmode 1. done: rca_o <= resp[31:16], go to DONE with done_o <= 1.
- cmd_err_i with cmd_done_i in CMD55, ACMD41, CMD2 or CMD3: ERR, code 3.
- ERR: err_o <= 1 on entry.
- DONE and ERR hold until start_i or reset.
- abort_i = 1 in any busy state: next cycle goes to ERR, code 4. No further cmd_start_o is issued. The in-flight command is not waited on, because the command FSM is reset by ABRT separately.
- Simultaneous events:
  - abort_i with cmd_done_i: abort wins; the response is discarded.
  - abort_i while not busy: no effect.
  - start_i with abort_i in IDLE: abort wins; stay in IDLE.
- cmd_done_i outside a WAIT phase is ignored.
- The retry counter is 16 bits and saturates; it never wraps.
- Reset mid-sequence: returns to reset values immediately, including dropping cmd_start_o and sd_clk_req_o.

Test Plan:
- v2 SDHC path: INIT_CLKS=80 → exactly 80 strobes with sd_clk_req_o high, then CMD0, CMD8 (resp 0x000001AA), ACMD41 resp 0x00FF8000 twice, then 0xC0FF8000, CMD2, CMD3 resp 0x12340000 → command sequence 0,8,55,41,55,41,55,41,2,3; rca_o=0x1234, ccs_o=1, v1_card_o=0, done_o=1, busy_o=0.
- v1 card: CMD8 completes with cmd_err_i → v1_card_o=1; ACMD41 arg = 0x00FF8000; final resp 0xC0FF8000 → ccs_o=0, done_o=1.
- CMD8 echo mismatch: resp 0x000001A5 → err_o=1, err_code_o=1; no CMD55 issued.
- Retry exhaustion with ACMD41_RETRIES=4: ACMD41 always resp 0x00FF8000 → exactly 4 ACMD41 issues, then err_code_o=2.
- Abort during ACMD41 WAIT, with cmd_done_i in the same cycle → err_code_o=4; no cmd_start_o afterwards. A following start_i restarts from PWRUP and clears err_o.
- Async reset asserted in the CMD2 WAIT phase → all outputs 0 before the next clock edge; start_i while busy → ignored, with no state change.
